// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared types and constants for the PC fetch sequencer: next-address select codes,
// FSM state encoding and the sequential PC increment.
package pc_fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_BRANCH = 2'd1,
    SEL_JUMP   = 2'd2,
    SEL_JREG   = 2'd3
  } pcSelT;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } stateT;

  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/pc_fetch_sequencer_next_pc_calc.sv
// Combinational next-PC resolution from decode/ALU control. All targets wrap modulo 2^PC_W.
module next_pc_calc
  import pc_fetch_sequencer_pkg::*;
#(
  parameter int unsigned PC_W = 16
) (
  input  logic [PC_W-1:0] pc,
  input  logic            Jump,
  input  logic            JumpFromReg,
  input  logic            Branch,
  input  logic            Zero,
  input  logic [15:0]     BranchOffset,
  input  logic [25:0]     JumpOffset,
  input  logic [15:0]     ReadData1,
  output logic [PC_W-1:0] nextPc,
  output pcSelT           sel
);

  logic [PC_W-1:0] seqPc;
  logic [PC_W-1:0] branchPc;
  logic [PC_W-1:0] jumpPc;
  logic [PC_W-1:0] regPc;

  // Word offsets become byte offsets; the size casts give the wrap with no sign extension.
  assign seqPc    = pc + PC_W'(PC_INC);
  assign branchPc = seqPc + PC_W'({BranchOffset, 2'b00});
  assign jumpPc   = PC_W'({JumpOffset, 2'b00});
  assign regPc    = PC_W'(ReadData1);

  always_comb begin
    nextPc = seqPc;
    sel    = SEL_SEQ;
    if (Jump && JumpFromReg) begin
      nextPc = regPc;
      sel    = SEL_JREG;
    end else if (Jump) begin
      nextPc = jumpPc;
      sel    = SEL_JUMP;
    end else if (Branch && Zero) begin
      nextPc = branchPc;
      sel    = SEL_BRANCH;
    end
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner: paces instruction fetch on the imem req/ack handshake, applies the
// resolved next-address select once per instruction, and handles halt and fetch timeout.
module pc_fetch_sequencer
  import pc_fetch_sequencer_pkg::*;
#(
  parameter int unsigned     PC_W        = 16,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int unsigned     ACK_TIMEOUT = 8
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  output logic            fetch_done,
  input  logic            ctrl_valid,
  input  logic            stall,
  input  logic            halt_req,
  input  logic            Jump,
  input  logic            JumpFromReg,
  input  logic            Branch,
  input  logic            Zero,
  input  logic [15:0]     BranchOffset,
  input  logic [25:0]     JumpOffset,
  input  logic [15:0]     ReadData1,
  output logic [PC_W-1:0] pc,
  output logic [1:0]      pc_sel,
  output logic [15:0]     instr_count,
  output logic            halted,
  output logic            fetch_err
);

  localparam logic [7:0] TimeoutMax = 8'(ACK_TIMEOUT);

  stateT           stateQ, stateD;
  logic [PC_W-1:0] pcQ, pcD;
  pcSelT           pcSelQ, pcSelD;
  logic [15:0]     instrCntQ, instrCntD;
  logic [7:0]      waitCntQ, waitCntD;
  logic            reqQ, reqD;
  logic            doneQ, doneD;
  logic            haltedQ, haltedD;
  logic            errQ, errD;

  logic [PC_W-1:0] nextPc;
  pcSelT           nextSel;
  logic [7:0]      waitCntInc;

  next_pc_calc #(
    .PC_W(PC_W)
  ) u_next_pc_calc (
    .pc          (pcQ),
    .Jump        (Jump),
    .JumpFromReg (JumpFromReg),
    .Branch      (Branch),
    .Zero        (Zero),
    .BranchOffset(BranchOffset),
    .JumpOffset  (JumpOffset),
    .ReadData1   (ReadData1),
    .nextPc      (nextPc),
    .sel         (nextSel)
  );

  assign waitCntInc = waitCntQ + 8'd1;

  always_comb begin
    stateD    = stateQ;
    pcD       = pcQ;
    pcSelD    = pcSelQ;
    instrCntD = instrCntQ;
    waitCntD  = waitCntQ;
    doneD     = 1'b0;
    errD      = errQ;
    unique case (stateQ)
      ST_RST: begin
        stateD   = ST_FETCH;
        waitCntD = '0;
      end
      ST_FETCH: begin
        // Ack wins over timeout, even on the last permitted cycle.
        if (imem_ack) begin
          stateD   = ST_EXEC;
          doneD    = 1'b1;
          waitCntD = '0;
        end else begin
          waitCntD = waitCntInc;
          if (waitCntInc == TimeoutMax) begin
            errD   = 1'b1;
            stateD = ST_HALT;
          end
        end
      end
      ST_EXEC: begin
        if (ctrl_valid && !stall) begin
          instrCntD = instrCntQ + 16'd1;
          if (halt_req) begin
            stateD = ST_HALT;
          end else begin
            pcD    = nextPc;
            pcSelD = nextSel;
            stateD = ST_FETCH;
          end
        end
      end
      ST_HALT: begin
      end
      default: stateD = ST_RST;
    endcase
    // Request and halted flag are registered copies of the state being entered.
    reqD    = (stateD == ST_FETCH);
    haltedD = (stateD == ST_HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ    <= ST_RST;
      pcQ       <= RESET_PC;
      pcSelQ    <= SEL_SEQ;
      instrCntQ <= '0;
      waitCntQ  <= '0;
      reqQ      <= 1'b0;
      doneQ     <= 1'b0;
      haltedQ   <= 1'b0;
      errQ      <= 1'b0;
    end else begin
      stateQ    <= stateD;
      pcQ       <= pcD;
      pcSelQ    <= pcSelD;
      instrCntQ <= instrCntD;
      waitCntQ  <= waitCntD;
      reqQ      <= reqD;
      doneQ     <= doneD;
      haltedQ   <= haltedD;
      errQ      <= errD;
    end
  end

  assign imem_req    = reqQ;
  assign imem_addr   = pcQ;
  assign pc          = pcQ;
  assign pc_sel      = pcSelQ;
  assign instr_count = instrCntQ;
  assign fetch_done  = doneQ;
  assign halted      = haltedQ;
  assign fetch_err   = errQ;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed scenarios with literal expectations, then random
// stimulus, all checked every cycle against a transaction-level model of the sequencer.
module tb_pc_fetch_sequencer;

  localparam int unsigned PcW     = 16;
  localparam int unsigned ResetPc = 0;
  localparam int unsigned Timeout = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic        fetch_done;
  logic        ctrl_valid = 1'b0;
  logic        stall = 1'b0;
  logic        halt_req = 1'b0;
  logic        Jump = 1'b0;
  logic        JumpFromReg = 1'b0;
  logic        Branch = 1'b0;
  logic        Zero = 1'b0;
  logic [15:0] BranchOffset = '0;
  logic [25:0] JumpOffset = '0;
  logic [15:0] ReadData1 = '0;
  logic [15:0] pc;
  logic [1:0]  pc_sel;
  logic [15:0] instr_count;
  logic        halted;
  logic        fetch_err;

  pc_fetch_sequencer #(
    .PC_W       (PcW),
    .RESET_PC   (16'(ResetPc)),
    .ACK_TIMEOUT(Timeout)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .fetch_done  (fetch_done),
    .ctrl_valid  (ctrl_valid),
    .stall       (stall),
    .halt_req    (halt_req),
    .Jump        (Jump),
    .JumpFromReg (JumpFromReg),
    .Branch      (Branch),
    .Zero        (Zero),
    .BranchOffset(BranchOffset),
    .JumpOffset  (JumpOffset),
    .ReadData1   (ReadData1),
    .pc          (pc),
    .pc_sel      (pc_sel),
    .instr_count (instr_count),
    .halted      (halted),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nErrors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase is what the sequencer is doing (0 reset, 1 waiting on fetch,
  // 2 executing, 3 halted); PC arithmetic done with plain integers modulo 2^16.
  bit          mValid = 1'b0;
  int          mPhase = 0;
  int unsigned mPc = 0, mSel = 0, mCnt = 0, mWait = 0;
  bit          mDone = 1'b0, mErr = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      mValid = 1'b1;
      mPhase = 0;
      mPc    = ResetPc;
      mSel   = 0;
      mCnt   = 0;
      mWait  = 0;
      mDone  = 1'b0;
      mErr   = 1'b0;
    end else if (mValid) begin
      mDone = 1'b0;
      case (mPhase)
        0: mPhase = 1;
        1: begin
          if (imem_ack) begin
            mPhase = 2;
            mDone  = 1'b1;
            mWait  = 0;
          end else begin
            mWait++;
            if (mWait == Timeout) begin
              mErr   = 1'b1;
              mPhase = 3;
            end
          end
        end
        2: begin
          if (ctrl_valid && !stall) begin
            mCnt = (mCnt + 1) % 65536;
            if (halt_req) begin
              mPhase = 3;
            end else begin
              if (Jump && JumpFromReg) begin
                mPc  = ReadData1;
                mSel = 3;
              end else if (Jump) begin
                mPc  = (int'(JumpOffset) * 4) % 65536;
                mSel = 2;
              end else if (Branch && Zero) begin
                mPc  = (mPc + 4 + int'(BranchOffset) * 4) % 65536;
                mSel = 1;
              end else begin
                mPc  = (mPc + 4) % 65536;
                mSel = 0;
              end
              mPhase = 1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (mValid) begin
      check("imem_req", imem_req, (mPhase == 1));
      check("imem_addr", imem_addr, mPc);
      check("pc", pc, mPc);
      check("pc_sel", pc_sel, mSel);
      check("instr_count", instr_count, mCnt);
      check("fetch_done", fetch_done, mDone);
      check("halted", halted, (mPhase == 3));
      check("fetch_err", fetch_err, mErr);
    end
  end

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic waitReq();
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_wait", imem_req, 1);
  endtask

  // lat cycles of FETCH without ack, then ack on the next one.
  task automatic fetch(input int lat);
    waitReq();
    repeat (lat) @(negedge clk);
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
  endtask

  task automatic exec(input bit j, input bit jr, input bit br, input bit z, input bit hr,
                      input logic [15:0] bo, input logic [25:0] jo, input logic [15:0] rd);
    Jump = j; JumpFromReg = jr; Branch = br; Zero = z; halt_req = hr;
    BranchOffset = bo; JumpOffset = jo; ReadData1 = rd;
    ctrl_valid = 1'b1;
    stall = 1'b0;
    @(negedge clk);
    ctrl_valid = 1'b0;
    Jump = 0; JumpFromReg = 0; Branch = 0; Zero = 0; halt_req = 0;
  endtask

  task automatic seq();
    exec(0, 0, 0, 0, 0, 16'h0, 26'h0, 16'h0);
  endtask

  task automatic jreg(input logic [15:0] target);
    fetch(0);
    exec(1, 1, 0, 0, 0, 16'h0, 26'h0, target);
  endtask

  int unsigned cntBefore;
  int unsigned pcBefore;

  initial begin
    doReset();
    check("rst_pc", pc, 16'h0000);
    check("rst_req", imem_req, 0);

    // Sequential fetch
    for (int i = 0; i < 3; i++) begin
      waitReq();
      check("seq_addr", imem_addr, 16'(i * 4));
      fetch(0);
      check("fetch_done_pulse", fetch_done, 1);
      seq();
    end
    check("seq_count", instr_count, 3);
    check("seq_pc", pc, 16'h000C);
    check("model_seq_pc", mPc, 16'h000C);

    // Branches
    fetch(0); seq();
    fetch(0); exec(0, 0, 1, 1, 0, 16'h0003, 26'h0, 16'h0);
    check("br_taken_pc", pc, 16'h0020);
    check("br_taken_sel", pc_sel, 1);
    check("model_br_pc", mPc, 16'h0020);
    jreg(16'h0010);
    fetch(0); exec(0, 0, 1, 0, 0, 16'h0003, 26'h0, 16'h0);
    check("br_not_taken_pc", pc, 16'h0014);
    check("br_not_taken_sel", pc_sel, 0);
    jreg(16'h0010);
    fetch(0); exec(0, 0, 1, 1, 0, 16'hFFFF, 26'h0, 16'h0);
    check("br_back_pc", pc, 16'h0010);
    check("model_br_back_pc", mPc, 16'h0010);

    // Jumps
    fetch(0); exec(1, 0, 0, 0, 0, 16'h0, 26'h0000040, 16'h0);
    check("jump_pc", pc, 16'h0100);
    check("jump_sel", pc_sel, 2);
    jreg(16'h1234);
    check("jr_pc", pc, 16'h1234);
    check("jr_sel", pc_sel, 3);
    fetch(0); exec(1, 0, 1, 1, 0, 16'h0007, 26'h0000055, 16'h0);
    check("jump_over_br_pc", pc, 16'h0154);
    check("jump_over_br_sel", pc_sel, 2);
    fetch(0); exec(0, 1, 0, 0, 0, 16'h0, 26'h0, 16'hBEEF);
    check("jr_no_jump_pc", pc, 16'h0158);
    check("jr_no_jump_sel", pc_sel, 0);

    // Wrap with stall
    jreg(16'hFFFC);
    fetch(0);
    cntBefore = mCnt;
    ctrl_valid = 1'b1;
    stall = 1'b1;
    repeat (5) @(negedge clk);
    check("stall_pc", pc, 16'hFFFC);
    check("stall_count", instr_count, cntBefore);
    check("stall_req", imem_req, 0);
    stall = 1'b0;
    @(negedge clk);
    ctrl_valid = 1'b0;
    check("wrap_pc", pc, 16'h0000);
    check("model_wrap_pc", mPc, 16'h0000);

    // Ack on the last permitted cycle
    fetch(Timeout - 1);
    check("late_ack_err", fetch_err, 0);
    check("late_ack_done", fetch_done, 1);
    seq();
    check("late_ack_pc", pc, 16'h0004);

    // Halt
    fetch(0);
    pcBefore  = mPc;
    cntBefore = mCnt;
    exec(0, 0, 0, 0, 1, 16'h0, 26'h0, 16'h0);
    check("halt_flag", halted, 1);
    check("halt_pc", pc, pcBefore);
    check("halt_count", instr_count, cntBefore + 1);
    imem_ack = 1'b1;
    ctrl_valid = 1'b1;
    repeat (4) @(negedge clk);
    imem_ack = 1'b0;
    ctrl_valid = 1'b0;
    check("halt_no_req", imem_req, 0);
    check("halt_absorbing", halted, 1);

    // Fetch timeout
    doReset();
    waitReq();
    repeat (Timeout - 1) @(negedge clk);
    check("to_not_yet", fetch_err, 0);
    @(negedge clk);
    check("to_err", fetch_err, 1);
    check("to_halted", halted, 1);
    check("to_no_req", imem_req, 0);

    // Reset during an outstanding fetch, with an ack arriving alongside
    doReset();
    fetch(0); seq();
    waitReq();
    @(negedge clk);
    reset = 1'b1;
    imem_ack = 1'b1;
    @(negedge clk);
    check("rst_mid_pc", pc, 16'(ResetPc));
    check("rst_mid_req", imem_req, 0);
    check("rst_mid_err", fetch_err, 0);
    reset = 1'b0;
    @(negedge clk);
    imem_ack = 1'b0;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 99) == 0);
      imem_ack     = $urandom_range(0, 1) == 1;
      ctrl_valid   = $urandom_range(0, 3) != 0;
      stall        = $urandom_range(0, 3) == 0;
      halt_req     = $urandom_range(0, 49) == 0;
      Jump         = $urandom_range(0, 3) == 0;
      JumpFromReg  = $urandom_range(0, 1) == 1;
      Branch       = $urandom_range(0, 1) == 1;
      Zero         = $urandom_range(0, 1) == 1;
      BranchOffset = 16'($urandom);
      JumpOffset   = 26'($urandom);
      ReadData1    = 16'($urandom);
      @(negedge clk);
    end
    reset = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Owns the program counter and sequences instruction fetch against the instruction-memory request/acknowledge handshake.
- Once per instruction, it resolves decode/ALU control (jump, jr, branch-taken, sequential) into a next-address select and updates the PC.
- It sits between the decode/ALU control outputs and the instruction memory.
- It replaces free-running per-clock PC updates with a handshake-paced FSM, and adds halt and fetch-timeout handling.

Parameters:
- PC_W, 16, program counter and address width.
- RESET_PC, 16'h0000, PC value loaded on reset.
- ACK_TIMEOUT, 8, maximum cycles imem_req may wait for imem_ack before a fetch error (range 1..255).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  PC_W  fetch address; always equals pc.
- imem_ack  input  1  instruction memory acknowledge; valid only while imem_req=1.
- fetch_done  output  1  one-cycle pulse on the cycle after ack is accepted.
- ctrl_valid  input  1  decode/ALU control for the current instruction is resolved.
- stall  input  1  hold in EXEC even if ctrl_valid=1.
- halt_req  input  1  halt instruction; sampled with ctrl_valid.
- Jump  input  1  jump instruction.
- JumpFromReg  input  1  jump target is a register (jr); meaningful only with Jump.
- Branch  input  1  branch instruction.
- Zero  input  1  ALU result zero.
- BranchOffset  input  16  word offset for branch.
- JumpOffset  input  26  word target for j/jal.
- ReadData1  input  16  rs value for jr.
- pc  output  PC_W  current PC register.
- pc_sel  output  2  last applied select: 0 SEQ, 1 BRANCH, 2 JUMP, 3 JREG.
- instr_count  output  16  count of completed instructions.
- halted  output  1  FSM in HALT.
- fetch_err  output  1  sticky; set on fetch timeout.

Behaviour:
- **States:** RST, FETCH, EXEC, HALT.
- **Reset:** when reset=1 at a clock edge:
  - state=RST, pc=RESET_PC, pc_sel=0, instr_count=0.
  - imem_req=0, fetch_done=0, halted=0, fetch_err=0, timeout counter=0.
- **Reset mid-operation:** reset overrides everything in any state, including an outstanding request. The request drops the next cycle; a late ack is ignored.
- **RST:** unconditionally goes to FETCH next cycle.
- **FETCH:**
  - imem_req=1 (registered: high for every FETCH cycle); imem_addr=pc.
  - If imem_ack=1: go to EXEC, pulse fetch_done the following cycle, clear the timeout counter.
  - Otherwise increment the timeout counter. When it reaches ACK_TIMEOUT without ack: set fetch_err, go to HALT.
  - Ack on exactly the ACK_TIMEOUT-th cycle is accepted; ack wins over timeout.
  - Best-case latency is FETCH (1 cycle, ack same cycle) → EXEC.
- **EXEC:**
  - imem_req=0; waits while ctrl_valid=0 or stall=1. Nothing changes while waiting.
  - On ctrl_valid=1 and stall=0, one action by priority:
    1. halt_req → HALT; pc unchanged; instr_count increments.
    2. Jump and JumpFromReg → pc=ReadData1, pc_sel=3.
    3. Jump → pc={JumpOffset[13:0],2'b00}, i.e. (JumpOffset<<2) truncated to 16 bits; pc_sel=2.
    4. Branch and Zero → pc=pc+4+{BranchOffset[13:0],2'b00}, modulo 2^16; pc_sel=1.
    5. Otherwise → pc=pc+4 modulo 2^16; pc_sel=0.
  - Cases 2–5: instr_count increments, modulo 2^16, and the FSM returns to FETCH.
  - Branch with Zero=0 is SEQ. JumpFromReg without Jump is ignored.
- **Wrap-around:** pc=16'hFFFC with SEQ gives 16'h0000. Branch arithmetic wraps identically. There is no sign extension beyond 16 bits; wrap provides backward branches.
- **HALT:** imem_req=0, halted=1; absorbing until reset. All inputs are ignored.
- **Output timing:** all outputs are registered; imem_addr is a direct copy of the pc register.
- **Throughput:** minimum 2 cycles per instruction (FETCH with immediate ack + EXEC with ctrl_valid).

Decomposition:
- **Shared package (parameters include):**
  - pc_sel codes: SEL_SEQ=0, SEL_BRANCH=1, SEL_JUMP=2, SEL_JREG=3.
  - FSM state encodings: ST_RST, ST_FETCH, ST_EXEC, ST_HALT.
  - PC_INC=4.
- **Sub-module:** one natural sub-module, next_pc_calc. It is purely combinational, taking pc plus the control/offset inputs and producing next_pc and sel. It is instantiated once; the FSM and counters stay in the parent.

Test Plan:
- **Reset and sequential fetch:** reset, then ack every FETCH cycle with ctrl_valid=1 and no control. imem_addr sequence is 0000, 0004, 0008; pc_sel=0; instr_count=3 after three EXECs.
- **Branch:** pc=0010, Branch=1, Zero=1, BranchOffset=0003 → pc=0020, pc_sel=1. Repeat with Zero=0 → pc=0014, pc_sel=0. BranchOffset=FFFF from pc=0010 → pc=0010.
- **Jump and jr:** JumpOffset=26'h0000040 → pc=0100, pc_sel=2. Jump=1, JumpFromReg=1, ReadData1=1234 → pc=1234, pc_sel=3. Both Jump and Branch&Zero set → jump taken.
- **Wrap, stall and ctrl_valid gating:** pc=FFFC with SEQ → pc=0000. Hold stall=1 for 5 cycles with ctrl_valid=1 → pc, state and instr_count frozen; the update occurs the cycle after stall drops.
- **Timeout and ack boundary:** ACK_TIMEOUT=8, never ack → fetch_err=1 and halted=1 after 8 FETCH cycles, imem_req=0 thereafter. Ack on the 8th cycle → no error, EXEC entered.
- **Halt and reset mid-fetch:**
  - halt_req with ctrl_valid → halted=1, pc unchanged, instr_count+1, no further imem_req.
  - Reset asserted during an outstanding FETCH → next cycle pc=RESET_PC, imem_req=0, fetch_err=0.
